i2c_tx_sequencer: RTL
=====================

I2C_TX_SEQUENCER -- requirements
Module: i2c_tx_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on scl_in and sda_in.
REQ-002 SHALL have parameter UNDERRUN_FILL, default 8'hFF, byte sent when no data is available.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port scl_in  input  1  raw I2C SCL pin level.
REQ-006 SHALL have port sda_in  input  1  raw I2C SDA pin level.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain).
REQ-008 SHALL have port start_read  input  1  one-cycle pulse from address stage: read addressed and ACKed, SCL high in ACK bit.
REQ-009 SHALL have port bus_abort  input  1  one-cycle pulse on detected STOP or repeated START.
REQ-010 SHALL have port tx_data  input  8  next byte to send, MSB first.
REQ-011 SHALL have port tx_valid  input  1  tx_data holds a byte.
REQ-012 SHALL have port tx_ready  output  1  one-cycle pulse: tx_data consumed this cycle.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse: UNDERRUN_FILL loaded instead of tx_data.
REQ-014 SHALL have port nack_seen  output  1  one-cycle pulse: controller NACKed a byte.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL synchronize scl_in, sda_in through SYNC_STAGES flops; scl_fall/scl_rise = change of synchronized SCL vs its previous-cycle value.
REQ-017 SHALL implement states IDLE, WAIT_FALL, SHIFT, ACK_REL, ACK_SAMPLE.
REQ-018 IDLE: sda_oe=0; on start_read go WAIT_FALL and perform a byte load (REQ-019).
REQ-019 Byte load: if tx_valid, shift register <= tx_data and tx_ready pulses that cycle; else shift register <= UNDERRUN_FILL and underrun pulses; never both.
REQ-020 WAIT_FALL: sda_oe unchanged; on scl_fall set sda_oe = ~shift[7], bit counter = 7, go SHIFT.
REQ-021 SHIFT: on scl_fall with counter > 0, shift left one, decrement counter, sda_oe = ~new shift[7]; SDA stable while SCL high.
REQ-022 SHIFT: on scl_fall with counter == 0, sda_oe=0, go ACK_REL.
REQ-023 ACK_REL: on scl_rise sample synchronized sda_in, go ACK_SAMPLE.
REQ-024 ACK_SAMPLE: sample 0 (ACK) -> byte load, go WAIT_FALL; sample 1 (NACK) -> nack_seen pulse, go IDLE, sda_oe stays 0.
REQ-025 sda_oe SHALL update on the clk edge after scl_fall is detected: SYNC_STAGES+1 clk edges after first edge sampling scl_in low.
REQ-026 bus_abort in any state SHALL force IDLE, sda_oe=0 next cycle, no tx_ready/underrun pulse; bus_abort wins over simultaneous start_read.
REQ-027 start_read outside IDLE SHALL be ignored.
REQ-028 tx_data/tx_valid changes after a load SHALL not affect the byte in flight.
REQ-029 scl_rise in WAIT_FALL/SHIFT and scl_fall in ACK_REL SHALL cause no state change.

Reset
REQ-030 While reset==0 at a clk edge: state=IDLE, sda_oe=0, tx_ready=0, underrun=0, nack_seen=0, busy=0, shift register=0, counter=0, synchronizers=1 (idle bus).
REQ-031 Reset mid-byte SHALL release SDA on the first reset edge; no pulse outputs during or on exit from reset.

Verification
REQ-032 tx_data=8'hA5, tx_valid=1, start_read, 9 SCL cycles with ACK -> sda_oe over bits = 0,1,0,1,1,0,1,0; tx_ready pulses twice (start, after ACK).
REQ-033 tx_valid=0 at start_read -> underrun pulse, bus carries 8'hFF (sda_oe=0 all 8 bits), no tx_ready.
REQ-034 bytes 8'h3C then 8'h81, controller NACKs second -> nack_seen one pulse after 18th SCL rise, busy falls, sda_oe=0.
REQ-035 bus_abort after 3rd bit of 8'h00 -> sda_oe 1->0 next cycle, IDLE, later start_read starts cleanly.
REQ-036 reset=0 while sda_oe=1 -> sda_oe=0 and busy=0 next edge; start_read while busy -> no effect.

Source files
------------

// File: rtl/i2c_tx_sequencer.sv
// I2C target transmit sequencer: shifts bytes onto SDA (open-drain) MSB first in
// response to a read addressed by an upstream stage, and samples the controller's ACK/NACK.
module i2c_tx_sequencer #(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] UNDERRUN_FILL = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       start_read,
  input  logic       bus_abort,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       underrun,
  output logic       nack_seen,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // Handshake: a byte load happens in the cycle the FSM decides to load; tx_ready is
  // asserted in that same cycle when tx_valid is high (tx_data is captured at the
  // closing clk edge), otherwise underrun is asserted and UNDERRUN_FILL is captured.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FALL  = 3'd1,
    SHIFT      = 3'd2,
    ACK_REL    = 3'd3,
    ACK_SAMPLE = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev;
  logic [7:0]             shift, shift_n;
  logic [2:0]             cnt, cnt_n;
  logic                   sda_oe_n;
  logic                   ack_bit, ack_bit_n;
  logic                   scl_s, sda_s, scl_fall, scl_rise;
  logic                   load, nack_p;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_fall = scl_prev & ~scl_s;
  assign scl_rise = ~scl_prev & scl_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      state    <= IDLE;
      shift    <= 8'h00;
      cnt      <= 3'd0;
      sda_oe   <= 1'b0;
      ack_bit  <= 1'b0;
    end else begin
      scl_sync[0] <= scl_in;
      sda_sync[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_prev <= scl_s;
      state    <= state_n;
      shift    <= shift_n;
      cnt      <= cnt_n;
      sda_oe   <= sda_oe_n;
      ack_bit  <= ack_bit_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    cnt_n     = cnt;
    sda_oe_n  = sda_oe;
    ack_bit_n = ack_bit;
    load      = 1'b0;
    nack_p    = 1'b0;
    if (bus_abort) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_n = 1'b0;
          if (start_read) begin
            load    = 1'b1;
            state_n = WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (scl_fall) begin
            sda_oe_n = ~shift[7];
            cnt_n    = 3'd7;
            state_n  = SHIFT;
          end
        end
        SHIFT: begin
          // Only SCL falls move data, so SDA never changes while SCL is high.
          if (scl_fall) begin
            if (cnt != 3'd0) begin
              shift_n  = {shift[6:0], 1'b0};
              cnt_n    = cnt - 3'd1;
              sda_oe_n = ~shift[6];
            end else begin
              sda_oe_n = 1'b0;
              state_n  = ACK_REL;
            end
          end
        end
        ACK_REL: begin
          if (scl_rise) begin
            ack_bit_n = sda_s;
            state_n   = ACK_SAMPLE;
          end
        end
        ACK_SAMPLE: begin
          if (!ack_bit) begin
            load    = 1'b1;
            state_n = WAIT_FALL;
          end else begin
            nack_p   = 1'b1;
            sda_oe_n = 1'b0;
            state_n  = IDLE;
          end
        end
        default: begin
          sda_oe_n = 1'b0;
          state_n  = IDLE;
        end
      endcase
    end
    if (load) begin
      shift_n = tx_valid ? tx_data : UNDERRUN_FILL;
    end
  end

  // Pulses are qualified by reset so nothing fires while reset is held.
  assign tx_ready  = reset & load & tx_valid;
  assign underrun  = reset & load & ~tx_valid;
  assign nack_seen = reset & nack_p;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
